// File: rtl/rv32i_mem_pkg.sv
// rtl/rv32i_mem_pkg.sv - shared types and helpers for the RV32I data-memory responder
// Contents: funct3 access codes, responder FSM state type, byte-enable type,
//           byte-enable and misalignment helper functions.
package rv32i_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef logic [3:0] byte_en_t;

  // Access size lives in funct3[1:0]; anything that is not B or H behaves as W.
  function automatic byte_en_t byte_en(input logic [2:0] f3, input logic [1:0] lo);
    if (f3[1:0] == F3_B[1:0]) begin
      return byte_en_t'(4'b0001 << lo);
    end else if (f3[1:0] == F3_H[1:0]) begin
      return lo[1] ? 4'b1100 : 4'b0011;
    end
    return 4'b1111;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    if (f3[1:0] == F3_B[1:0]) begin
      return 1'b0;
    end else if (f3[1:0] == F3_H[1:0]) begin
      return lo[0];
    end
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of a loaded word
// Ports: word    - raw 32-bit RAM word
//        addr_lo - byte offset within the word
//        funct3  - access size/sign (B, H, W, BU, HU; reserved codes act as W)
//        data    - right-aligned, extended load result
module load_extend
  import rv32i_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*addr_lo +: 8];
    // Halfword uses addr_lo[1] only, so an odd half address aligns down.
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    data     = word;
    if (funct3[1:0] == F3_B[1:0]) begin
      data = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (funct3[1:0] == F3_H[1:0]) begin
      data = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - RV32I data-memory responder with fixed-latency load handshake
// Ports: clk, rst (async active low); load/store requests with funct3, addr, wdata;
//        rdata (extended load result), DM_valid (one-cycle completion pulse),
//        busy (high in WAIT/RESP).
// Optional: define DMEM_MISALIGN_TRAP_EN to add output misaligned, which blocks
//        misaligned stores and zeroes misaligned load results; otherwise low
//        address bits are aligned down.
module dmem_resp
  import rv32i_mem_pkg::*;
#(
  parameter int ADDRESS = 32,
  parameter int DATA    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               store,
  input  logic [2:0]         funct3,
  input  logic [ADDRESS-1:0] addr,
  input  logic [DATA-1:0]    wdata,
  output logic [DATA-1:0]    rdata,
  output logic               DM_valid,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic               misaligned,
`endif
  output logic               busy
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA-1:0] mem [DEPTH];

  dmem_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic [1:0]      lo_q, lo_d;
  logic [2:0]      f3_q, f3_d;
  logic [DATA-1:0] rdata_q, rdata_d;
  logic            dm_valid_q, dm_valid_d;
  logic            busy_q, busy_d;
  logic            mis_q, mis_d;

  logic [DATA-1:0] rd_word, rd_ext;
  logic            ld_mis, st_mis;
  logic            wr_en;
  byte_en_t        wr_be;
  logic [DATA-1:0] wr_data;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^addr[ADDRESS-1:AW+2];

  assign rd_word = mem[widx_q];

  load_extend u_ext (
    .word    (rd_word),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .data    (rd_ext)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign ld_mis = is_misaligned(f3_q, lo_q);
  assign st_mis = is_misaligned(funct3, addr[1:0]);
`else
  assign ld_mis = 1'b0;
  assign st_mis = 1'b0;
`endif

  // A store sampled while rst is low is dropped along with everything else.
  assign wr_en = store && rst && !st_mis;
  assign wr_be = byte_en(funct3, addr[1:0]);

  always_comb begin
    wr_data = wdata;
    if (funct3[1:0] == F3_B[1:0]) begin
      wr_data = {4{wdata[7:0]}};
    end else if (funct3[1:0] == F3_H[1:0]) begin
      wr_data = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    lo_d       = lo_q;
    f3_d       = f3_q;
    rdata_d    = rdata_q;
    dm_valid_d = 1'b0;
    mis_d      = store && rst && st_mis;
    case (state_q)
      IDLE: begin
        // A simultaneous store wins; the load is simply not accepted.
        if (load && !store) begin
          widx_d  = addr[AW+1:2];
          lo_d    = addr[1:0];
          f3_d    = funct3;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // RAM write lands at this same edge, so the read sees the old word.
          rdata_d    = ld_mis ? '0 : rd_ext;
          dm_valid_d = 1'b1;
          mis_d      = mis_d || ld_mis;
          state_d    = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      widx_q     <= '0;
      lo_q       <= '0;
      f3_q       <= '0;
      rdata_q    <= '0;
      dm_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      lo_q       <= lo_d;
      f3_q       <= f3_d;
      rdata_q    <= rdata_d;
      dm_valid_q <= dm_valid_d;
      busy_q     <= busy_d;
      mis_q      <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[addr[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rdata    = rdata_q;
  assign DM_valid = dm_valid_q;
  assign busy     = busy_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule
